// File: rtl/rvfi_commit_sched_if.sv
// Requester-side and RVFI-slot-side signal bundle for rvfi_commit_sched.
// master = retirement producers / RVFI consumer side, slave = the scheduler.
interface rvfi_commit_sched_if #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned PKT_W = 512
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic [NREQ-1:0]       req_halt;
    logic [NREQ*PKT_W-1:0] req_pkt;
    logic [3:0]            commit;
    logic [3:0]            halt;
    logic [255:0]          order;
    logic [4*PKT_W-1:0]    pkt_out;
    logic [15:0]           errcode;

    modport master (
        output req_valid, req_tag, req_halt, req_pkt,
        input  req_ready, commit, halt, order, pkt_out, errcode
    );

    modport slave (
        input  req_valid, req_tag, req_halt, req_pkt,
        output req_ready, commit, halt, order, pkt_out, errcode
    );
endinterface

// File: rtl/rvfi_commit_sched.sv
// Retirement reorder window feeding four RVFI slots with in-order packets and 64-bit order numbers.
// Optional watchdog on stalled heads: define RVFI_COMMIT_SCHED_WATCHDOG_EN.
module rvfi_commit_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TAG_W   = $clog2(DEPTH) + 1,
    parameter int unsigned PKT_W   = 512
`ifdef RVFI_COMMIT_SCHED_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT = 1024
`endif
) (
    input logic                clk,
    input logic                rst,
    rvfi_commit_sched_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   head_q, head_d;
    logic [63:0]        order_cnt_q, order_cnt_d;
    logic [DEPTH-1:0]   ent_valid_q, ent_valid_d;
    logic [DEPTH-1:0]   ent_halt_q, ent_halt_d;
    logic [PKT_W-1:0]   ent_pkt_q [DEPTH];

    logic [NREQ-1:0]    ready;
    logic [NREQ-1:0]    accept;
    logic [2:0]         err_flags;
    logic [2:0]         k;
    logic               halt_hit;
    logic [IDX_W-1:0]   drain_idx [4];
    logic               wd_fire;

    logic [3:0]         commit_q, commit_d;
    logic [3:0]         halt_q, halt_d;
    logic [255:0]       order_q, order_d;
    logic [4*PKT_W-1:0] pkt_q, pkt_d;
    logic [15:0]        errcode_q, errcode_d;

    // Per-requester acceptance and error classification against the current window.
    always_comb begin
        ready     = '0;
        err_flags = '0;
        for (int i = 0; i < NREQ; i++) begin : g_req
            logic [TAG_W-1:0] tag;
            logic [TAG_W-1:0] off;
            logic             in_win;
            logic             occ;
            logic             dup;
            tag    = bus.req_tag[i*TAG_W +: TAG_W];
            off    = tag - head_q;
            in_win = off < TAG_W'(DEPTH);
            occ    = ent_valid_q[tag[IDX_W-1:0]];
            dup    = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (bus.req_valid[j] && (bus.req_tag[j*TAG_W +: TAG_W] == tag)) begin
                    dup = 1'b1;
                end
            end
            if (state_q == StRun) begin
                ready[i] = in_win && !occ && !dup;
                if (bus.req_valid[i]) begin
                    if (!in_win) begin
                        err_flags[2] = 1'b1;
                    end else begin
                        if (occ) err_flags[0] = 1'b1;
                        if (dup) err_flags[1] = 1'b1;
                    end
                end
            end
        end
    end

    assign accept        = bus.req_valid & ready;
    assign bus.req_ready = ready;

    // Count the in-order run at head, stopping after a halt entry.
    always_comb begin
        logic run;
        k        = '0;
        halt_hit = 1'b0;
        run      = (state_q == StRun);
        for (int j = 0; j < 4; j++) begin
            drain_idx[j] = head_q[IDX_W-1:0] + IDX_W'(j);
            if (run && ent_valid_q[drain_idx[j]]) begin
                k = 3'(j + 1);
                if (ent_halt_q[drain_idx[j]]) begin
                    halt_hit = 1'b1;
                    run      = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

`ifdef RVFI_COMMIT_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;

    logic [WD_W-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (k != 3'd0) begin
            wd_d = '0;
        end else if ((state_q == StRun) && (|ent_valid_q) && (wd_q != WD_W'(TIMEOUT))) begin
            wd_d = wd_q + WD_W'(1);
        end
        wd_fire = (wd_d == WD_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        head_d      = head_q + TAG_W'(k);
        order_cnt_d = order_cnt_q + 64'(k);
        ent_valid_d = ent_valid_q;
        ent_halt_d  = ent_halt_q;
        commit_d    = '0;
        halt_d      = '0;
        order_d     = '0;
        pkt_d       = '0;
        errcode_d   = errcode_q | {12'h000, wd_fire, err_flags};

        if ((state_q == StRun) && halt_hit) begin
            state_d = StHalted;
        end

        for (int j = 0; j < 4; j++) begin
            if (3'(j) < k) begin
                ent_valid_d[drain_idx[j]]   = 1'b0;
                ent_halt_d[drain_idx[j]]    = 1'b0;
                commit_d[j]                 = 1'b1;
                halt_d[j]                   = ent_halt_q[drain_idx[j]];
                order_d[j*64 +: 64]         = order_cnt_q + 64'(j);
                pkt_d[j*PKT_W +: PKT_W]     = ent_pkt_q[drain_idx[j]];
            end
        end

        // Accepted tags are never among the drained ones: drained entries are already valid.
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                ent_valid_d[bus.req_tag[i*TAG_W +: IDX_W]] = 1'b1;
                ent_halt_d[bus.req_tag[i*TAG_W +: IDX_W]]  = bus.req_halt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            head_q      <= '0;
            order_cnt_q <= '0;
            ent_valid_q <= '0;
            ent_halt_q  <= '0;
            commit_q    <= '0;
            halt_q      <= '0;
            order_q     <= '0;
            pkt_q       <= '0;
            errcode_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            order_cnt_q <= order_cnt_d;
            ent_valid_q <= ent_valid_d;
            ent_halt_q  <= ent_halt_d;
            commit_q    <= commit_d;
            halt_q      <= halt_d;
            order_q     <= order_d;
            pkt_q       <= pkt_d;
            errcode_q   <= errcode_d;
        end
    end

    // Payload storage is qualified by ent_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                ent_pkt_q[bus.req_tag[i*TAG_W +: IDX_W]] <= bus.req_pkt[i*PKT_W +: PKT_W];
            end
        end
    end

    assign bus.commit  = commit_q;
    assign bus.halt    = halt_q;
    assign bus.order   = order_q;
    assign bus.pkt_out = pkt_q;
    assign bus.errcode = errcode_q;
endmodule

// File: tb/tb_rvfi_commit_sched.sv
// Scoreboard bench for rvfi_commit_sched: an absolute-sequence reference model predicts commits,
// a negedge monitor pops and compares them.
module tb_rvfi_commit_sched;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned PKT_W = 512;
    localparam int          TAGS  = 32;

    typedef struct {
        longint           ord;
        logic [PKT_W-1:0] pkt;
        bit               hlt;
        int               slot;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: entries keyed by absolute program sequence number.
    int               m_head   = 0;
    bit               m_halted = 1'b0;
    logic [15:0]      m_err    = '0;
    logic [PKT_W-1:0] m_pkt [int];
    bit               m_hlt [int];
    exp_t             expq [$];

    always #5 clk = ~clk;

    rvfi_commit_sched_if #(.NREQ(NREQ), .TAG_W(TAG_W), .PKT_W(PKT_W)) bus ();

    rvfi_commit_sched #(
        .NREQ (NREQ),
        .DEPTH(DEPTH),
        .TAG_W(TAG_W),
        .PKT_W(PKT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [PKT_W-1:0] act,
                       input logic [PKT_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int tag_of(input int i);
        return int'(bus.req_tag[i*TAG_W +: TAG_W]);
    endfunction

    function automatic int off_of(input int i);
        return (tag_of(i) - m_head) & (TAGS - 1);
    endfunction

    function automatic bit dup_below(input int i);
        for (int j = 0; j < i; j++) begin
            if (bus.req_valid[j] && tag_of(j) == tag_of(i)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_ready(input int i);
        if (m_halted || off_of(i) >= DEPTH) return 1'b0;
        if (m_pkt.exists(m_head + off_of(i))) return 1'b0;
        return !dup_below(i);
    endfunction

    function automatic logic [2:0] m_err_of(input int i);
        logic [2:0] e;
        e = '0;
        if (m_halted || !bus.req_valid[i]) return e;
        if (off_of(i) >= DEPTH) begin
            e[2] = 1'b1;
        end else begin
            if (m_pkt.exists(m_head + off_of(i))) e[0] = 1'b1;
            if (dup_below(i)) e[1] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [PKT_W-1:0] rand_pkt();
        logic [PKT_W-1:0] p;
        for (int w = 0; w < PKT_W / 32; w++) p[w*32 +: 32] = $urandom();
        return p;
    endfunction

    // One clock edge of the specification's rules: accept against pre-edge state, drain the
    // in-order run at head (max 4, stop after halt), then install the accepted packets.
    task automatic model_step();
        int               acc_seq [$];
        logic [PKT_W-1:0] acc_pkt [$];
        bit               acc_h [$];
        logic [2:0]       e;
        int               k;
        e = '0;
        k = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i]) begin
                if (m_ready(i)) begin
                    acc_seq.push_back(m_head + off_of(i));
                    acc_pkt.push_back(bus.req_pkt[i*PKT_W +: PKT_W]);
                    acc_h.push_back(bus.req_halt[i]);
                end
                e |= m_err_of(i);
            end
        end
        cyc++;
        if (!m_halted) begin
            while (k < 4 && m_pkt.exists(m_head + k)) begin
                exp_t x;
                x.ord  = longint'(m_head + k);
                x.pkt  = m_pkt[m_head + k];
                x.hlt  = m_hlt[m_head + k];
                x.slot = k;
                x.cyc  = cyc;
                expq.push_back(x);
                m_pkt.delete(m_head + k);
                m_hlt.delete(m_head + k);
                k++;
                if (x.hlt) begin
                    m_halted = 1'b1;
                    break;
                end
            end
        end
        m_head += k;
        foreach (acc_seq[a]) begin
            m_pkt[acc_seq[a]] = acc_pkt[a];
            m_hlt[acc_seq[a]] = acc_h[a];
        end
        m_err[2:0] |= e;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) model_step();
        end
    end

    // Monitor: pop one expected entry per committed slot; idle slots must read zero.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int j = 0; j < 4; j++) begin
                    if (bus.commit[j]) begin
                        if (expq.size() == 0) begin
                            chk("unexpected_commit_slot", PKT_W'(j), PKT_W'(4));
                        end else begin
                            exp_t x;
                            x = expq.pop_front();
                            chk("commit_order", bus.order[j*64 +: 64], PKT_W'(x.ord));
                            chk("commit_slot", PKT_W'(j), PKT_W'(x.slot));
                            chk("commit_cycle", PKT_W'(cyc), PKT_W'(x.cyc));
                            chk("commit_pkt", bus.pkt_out[j*PKT_W +: PKT_W], x.pkt);
                            chk("commit_halt", PKT_W'(bus.halt[j]), PKT_W'(x.hlt));
                        end
                    end else begin
                        chk("idle_halt", PKT_W'(bus.halt[j]), '0);
                        chk("idle_order", bus.order[j*64 +: 64], '0);
                        chk("idle_pkt", bus.pkt_out[j*PKT_W +: PKT_W], '0);
                    end
                end
                if (expq.size() > 0) begin
                    chk("commit_overdue", PKT_W'(expq[0].cyc <= cyc), '0);
                end
                chk("errcode", bus.errcode, m_err);
            end
        end
    end

    task automatic apply(input bit v0, input int t0, input bit h0,
                         input bit v1, input int t1, input bit h1);
        bus.req_valid = {v1, v0};
        bus.req_tag   = {TAG_W'(t1), TAG_W'(t0)};
        bus.req_halt  = {h1, h0};
        bus.req_pkt   = {rand_pkt(), rand_pkt()};
        #1;
        for (int i = 0; i < NREQ; i++) chk("req_ready", PKT_W'(bus.req_ready[i]), PKT_W'(m_ready(i)));
    endtask

    task automatic drive(input bit v0, input int t0, input bit h0,
                         input bit v1, input int t1, input bit h1);
        @(negedge clk);
        #1;
        apply(v0, t0, h0, v1, t1, h1);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic rand_cycle(input int span, input bit clean);
        bit v [2];
        int t [2];
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            int o;
            o    = int'($urandom_range(0, span - 1));
            v[i] = ($urandom_range(0, 9) < 7);
            t[i] = (m_head + o) & (TAGS - 1);
            if (clean && m_pkt.exists(m_head + o)) v[i] = 1'b0;
        end
        if (clean && v[0] && v[1] && t[0] == t[1]) v[1] = 1'b0;
        apply(v[0], t[0], 1'b0, v[1], t[1], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        bus.req_valid = '0;
        bus.req_halt  = '0;
        rst = 1'b0;
        #1;
        chk("rst_commit", PKT_W'(bus.commit), '0);
        chk("rst_halt", PKT_W'(bus.halt), '0);
        chk("rst_order", PKT_W'(|bus.order), '0);
        chk("rst_pkt_out", PKT_W'(|bus.pkt_out), '0);
        chk("rst_errcode", PKT_W'(bus.errcode), '0);
        chk("rst_ready", PKT_W'(bus.req_ready), PKT_W'(2'b11));
        m_pkt.delete();
        m_hlt.delete();
        m_head   = 0;
        m_halted = 1'b0;
        m_err    = '0;
        expq.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_halt  = '0;
        bus.req_pkt   = '0;

        // In-order singles from requester 0.
        do_reset();
        drive(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
        idle(4);

        // Younger tag first, then head: both commit together.
        do_reset();
        drive(1'b0, 0, 1'b0, 1'b1, 1, 1'b0);
        drive(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
        idle(1);
        @(negedge clk);
        #1;
        chk("pair_commit", PKT_W'(bus.commit), PKT_W'(4'b0011));
        chk("pair_order1", bus.order[127:64], PKT_W'(1));
        idle(2);

        // Out-of-order fill 1..5, then head 0: 4-wide drain followed by 2.
        do_reset();
        drive(1'b1, 5, 1'b0, 1'b1, 3, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b1, 4, 1'b0);
        drive(1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
        idle(1);
        drive(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
        idle(4);

        // Halt truncates the drain and freezes the scheduler.
        do_reset();
        drive(1'b1, 2, 1'b0, 1'b1, 1, 1'b1);
        drive(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
        idle(3);
        drive(1'b1, 3, 1'b0, 1'b1, 4, 1'b0);
        chk("halted_ready", PKT_W'(bus.req_ready), '0);
        idle(4);

        // Error flags: duplicate tag, out-of-window tag, occupied entry.
        do_reset();
        drive(1'b1, 3, 1'b0, 1'b1, 3, 1'b0);
        idle(1);
        chk("dup_errcode", PKT_W'(bus.errcode), PKT_W'(16'h0002));
        drive(1'b1, 20, 1'b0, 1'b0, 0, 1'b0);
        idle(1);
        chk("window_errcode", PKT_W'(bus.errcode), PKT_W'(16'h0006));
        drive(1'b0, 0, 1'b0, 1'b1, 3, 1'b0);
        idle(1);
        chk("occupied_errcode", PKT_W'(bus.errcode), PKT_W'(16'h0007));
        drive(1'b1, 0, 1'b0, 1'b1, 1, 1'b0);
        drive(1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
        idle(4);

        // Randomized out-of-order traffic across many tag wraps, then a noisy tail.
        do_reset();
        for (int c = 0; c < 2500; c++) rand_cycle(16, 1'b1);
        for (int c = 0; c < 200; c++) rand_cycle(24, 1'b0);
        for (int c = 0; c < 40; c++) rand_cycle(16, 1'b1);
        idle(2);
        for (int n = 0; n < 20 && expq.size() > 0; n++) idle(1);
        chk("queue_drained", PKT_W'(expq.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rvfi_commit_sched.md
# rvfi_commit_sched

Retirement scheduler feeding the 4-slot RVFI monitor bus. Accepts retirement packets from several pipeline requesters, which may arrive out of program order, and buffers them in a tag-indexed reorder window. Each cycle it drains up to 4 consecutive in-order packets into RVFI slots 0..3 and assigns monotonically increasing 64-bit order numbers. Sits between the core's writeback/retire points and the RVFI monitor/checker.

## Interface

- NREQ, 2, number of retirement requesters
- DEPTH, 16, reorder window entries (power of 2, ≥4)
- TAG_W, $clog2(DEPTH)+1, program-order tag width (wraps mod 2^TAG_W)
- PKT_W, 512, opaque per-instruction payload width (inst, pc, rs/rd, mem fields, packed by producer)
- TIMEOUT, 1024, watchdog cycles (only with macro)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock domain, reset is asynchronous and active-low (asserted at 0)
- req_valid  in  NREQ  requester i offers a packet
- req_ready  out  NREQ  requester i packet accepted this cycle when valid&ready
- req_tag  in  NREQ*TAG_W  program-order tag per requester
- req_halt  in  NREQ  packet is the halting instruction
- req_pkt  in  NREQ*PKT_W  payload per requester
- commit  out  4  slot i carries a retired instruction
- halt  out  4  slot i retired instruction is the halt
- order  out  256  64-bit order number per slot
- pkt_out  out  4*PKT_W  payload per slot
- errcode  out  16  sticky error flags

## Operation

- Storage: DEPTH entries {valid, halt, pkt}, indexed by tag[log2 DEPTH-1:0]; head_tag register (TAG_W), order_cnt (64-bit).
- Accept rule for requester i: req_ready[i]=1 iff state==RUN, (req_tag-head_tag) mod 2^TAG_W < DEPTH, target entry empty, and no lower-index requester presents the same tag this cycle. req_ready is combinational from req_tag/state/entry state; it does not depend on req_valid of i.
- Drain: k = number of consecutive valid entries starting at head, capped at 4; if an entry among them has halt set, k truncates to include the halt entry and nothing after it.
- Drained entry j (0≤j<k) goes to slot j: commit[j]=1, order[j]=order_cnt+j, pkt_out[j]=pkt, halt[j]=entry halt. Slots ≥k: commit=0, halt=0, order/pkt_out hold 0.
- Update: head_tag += k (mod 2^TAG_W), order_cnt += k, drained entries cleared. A write and a drain of the same entry never coincide (head entries are already valid).
- States: RUN → HALTED when a halt entry drains. HALTED: req_ready=0, commit=0, all further input ignored; exit only by reset.
- errcode (sticky, cleared only by reset): bit0 valid tag to already-occupied entry; bit1 two requesters same tag same cycle; bit2 valid tag outside window; bit3 watchdog (macro); bits 15:4 zero. Error-flagged packets are dropped.

## Timing

- Reset (rst=0, async): commit, halt, order, pkt_out, errcode = 0; head_tag=0, order_cnt=0, all entries empty, state RUN. req_ready reflects the reset state immediately.
- Accept at edge E; if entry is at head, it appears on commit in the cycle after edge E+1 (drain logic registered, 1-cycle bypass-free latency).
- All RVFI outputs registered; commit pulses for exactly one cycle per instruction.
- Reset deasserted mid-stream: all buffered packets discarded; first packet after reset gets order 0.
- Tag wrap: window comparison in modulo arithmetic; head_tag 2^TAG_W-1 → 0 is seamless.
- Full window: when all DEPTH entries are valid but head is empty, this cannot occur; when head..head+DEPTH-1 are all valid, 4 drain per cycle.

## Configuration

- RVFI_COMMIT_SCHED_WATCHDOG_EN defined: 11-bit counter (sized for TIMEOUT) counts cycles in RUN with at least one entry valid and k=0; reaching TIMEOUT sets errcode[3]; counter clears on any drain. Not defined: no counter, errcode[3] tied 0.

## Test plan

- Reset, requester0 sends tags 0,1,2 in consecutive cycles → commit=0001 for three cycles, order 0,1,2.
- Requester1 sends tag 1, then requester0 sends tag 0 → single cycle commit=0011, order[63:0]=0, order[127:64]=1.
- Fill tags 0..5 out of order, then supply missing tag 0 → commit=1111 (orders 0..3), next cycle commit=0011 (orders 4,5).
- Tags 0,1(halt),2 all buffered → commit=0011, halt=0010; afterwards req_ready=00, tag 2 never commits.
- Both requesters offer tag 3 same cycle → req_ready=01, errcode=0x0002; tag 20 with head 0, DEPTH 16 → errcode bit2 set.
- Macro on, TIMEOUT=8: buffer tag 1 only → errcode[3]=1 after 8 cycles; rst pulse mid-run → all outputs 0, next tag 0 gets order 0.
